// File: rtl/gate_vector_sequencer.sv
// Exhaustive input-vector source for an N-input gate under test: walks 0..2^N-1 for PASSES sweeps.
// Latency: first vector one cycle after start is sampled, then one vector per cycle while out_ready is high.
// Backpressure: out_valid/out_data/out_last hold stable while out_ready is low; nothing is dropped.
//
// Ports:
//   clk, rst_n         clock and synchronous active-low reset
//   start, abort       run request (IDLE/DONE only) and run cancel (RUN only)
//   out_valid/ready    vector handshake; out_data is the gate input vector
//   out_last           marks the final vector of the run
//   busy, done         run in progress / run finished normally (held until next start)
//   vec_count          accepted transfers this run, saturating
//   cov_pct            floor(100 * unique vectors accepted / 2^N_INPUTS)
module gate_vector_sequencer #(
  parameter int N_INPUTS = 2,
  parameter int PASSES   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [N_INPUTS-1:0] out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic [15:0]         vec_count,
  output logic [6:0]          cov_pct
);

  localparam int                 NV        = 1 << N_INPUTS;
  localparam int                 UW        = N_INPUTS + 1;
  localparam logic [N_INPUTS-1:0] MAX_VEC  = '1;
  localparam logic [7:0]         LAST_PASS = 8'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [7:0]          pass;
  logic [NV-1:0]       bitmap;
  logic [UW-1:0]       uniq;

  logic                xfer;
  logic                enter;
  logic                wrap;
  logic [N_INPUTS-1:0] data_nxt;
  logic [7:0]          pass_nxt;
  logic                last_nxt;
  logic                new_hit;
  logic [UW-1:0]       uniq_nxt;
  logic [15:0]         cov_prod;
  logic [6:0]          cov_nxt;
  logic [15:0]         vec_nxt;

  always_comb begin
    xfer     = (state == RUN) && out_valid && out_ready;
    // start in DONE restarts regardless of abort; in IDLE abort wins over start.
    enter    = start && (((state == IDLE) && !abort) || (state == DONE));
    wrap     = (out_data == MAX_VEC);
    data_nxt = out_data + N_INPUTS'(1);
    pass_nxt = pass + 8'(wrap);
    last_nxt = (data_nxt == MAX_VEC) && (pass_nxt == LAST_PASS);
    new_hit  = !bitmap[out_data];
    uniq_nxt = uniq + UW'(new_hit);
    // Dividing by 2^N is a plain shift; coverage is computed from the post-transfer
    // count so the registered value lands in the cycle right after the transfer.
    cov_prod = 16'(uniq_nxt) * 16'd100;
    cov_nxt  = 7'(cov_prod >> N_INPUTS);
    vec_nxt  = (vec_count == 16'hFFFF) ? vec_count : vec_count + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vec_count <= '0;
      cov_pct   <= '0;
      pass      <= '0;
      bitmap    <= '0;
      uniq      <= '0;
    end else if (enter) begin
      state     <= RUN;
      out_valid <= 1'b1;
      out_data  <= '0;
      // A run ends on vector 0 only if there is a single vector per pass, which N>=1 rules out.
      out_last  <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      vec_count <= '0;
      cov_pct   <= '0;
      pass      <= '0;
      bitmap    <= '0;
      uniq      <= '0;
    end else if (state == RUN) begin
      // Bookkeeping for an accepted vector happens even when abort arrives in the same cycle.
      if (xfer) begin
        vec_count        <= vec_nxt;
        bitmap[out_data] <= 1'b1;
        uniq             <= uniq_nxt;
        cov_pct          <= cov_nxt;
      end
      if (abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else if (xfer) begin
        if (out_last) begin
          state     <= DONE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end else begin
          out_data <= data_nxt;
          pass     <= pass_nxt;
          out_last <= last_nxt;
        end
      end
    end
  end

endmodule
